// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl
// ----------------
// Scan/refresh sequencer for a HUB75 LED matrix panel. For every row and
// bit-plane it shifts COLS columns out (two ticks per column), latches them,
// and then holds OE low for BASE_TICKS*2^plane ticks (binary-coded modulation).
// Only the tick_i enable from the upstream prescaler advances it.
//
// Handshake: none. tick_i is a one-clk qualifier. run_i is sampled only on a
// tick while idle or while in NEXT, so a row-plane that has started always
// finishes before the block stops.
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   tick_i        one-cycle advance enable
//   run_i         1 = keep scanning
//   rd_col_o      framebuffer column being shifted
//   rd_row_o      framebuffer row being shifted
//   rd_plane_o    bit-plane being shifted
//   hub_clk_o     panel shift clock
//   hub_lat_o     panel latch
//   hub_oe_n_o    panel output enable, active low
//   hub_addr_o    panel row address
//   busy_o        sequencer not idle
//   frame_done_o  one-clk pulse when the last row/plane of a frame retires
//   state_o       current FSM state (debug)
module hub75_scan_ctrl #(
  parameter int COLS       = 64,
  parameter int COL_BITS   = 6,
  parameter int ADDR_BITS  = 4,
  parameter int PLANES     = 4,
  parameter int PLANE_BITS = 2,
  parameter int BASE_TICKS = 1,
  parameter int DISP_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_i,
  input  logic                  run_i,
  output logic [COL_BITS-1:0]   rd_col_o,
  output logic [ADDR_BITS-1:0]  rd_row_o,
  output logic [PLANE_BITS-1:0] rd_plane_o,
  output logic                  hub_clk_o,
  output logic                  hub_lat_o,
  output logic                  hub_oe_n_o,
  output logic [ADDR_BITS-1:0]  hub_addr_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    LATCH   = 3'd2,
    DISPLAY = 3'd3,
    NEXT    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [COL_BITS-1:0]   col_q, col_d;
  logic [ADDR_BITS-1:0]  row_q, row_d;
  logic [PLANE_BITS-1:0] plane_q, plane_d;
  logic                  phase_q, phase_d;
  logic [DISP_BITS-1:0]  disp_cnt_q, disp_cnt_d;
  logic                  hub_clk_q, hub_clk_d;
  logic                  hub_lat_q, hub_lat_d;
  logic                  hub_oe_n_q, hub_oe_n_d;
  logic [ADDR_BITS-1:0]  hub_addr_q, hub_addr_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;

  logic                  col_last;
  logic                  plane_last;
  logic                  row_last;
  logic [DISP_BITS-1:0]  disp_load;

  assign col_last   = (col_q == COL_BITS'(COLS - 1));
  assign plane_last = (plane_q == PLANE_BITS'(PLANES - 1));
  assign row_last   = &row_q;
  // Counter runs load..0 inclusive, giving BASE_TICKS<<plane OE-low ticks.
  assign disp_load  = (DISP_BITS'(BASE_TICKS) << plane_q) - DISP_BITS'(1);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      phase_q      <= 1'b0;
      disp_cnt_q   <= '0;
      hub_clk_q    <= 1'b0;
      hub_lat_q    <= 1'b0;
      hub_oe_n_q   <= 1'b1;
      hub_addr_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      phase_q      <= phase_d;
      disp_cnt_q   <= disp_cnt_d;
      hub_clk_q    <= hub_clk_d;
      hub_lat_q    <= hub_lat_d;
      hub_oe_n_q   <= hub_oe_n_d;
      hub_addr_q   <= hub_addr_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (tick_i) begin
      case (state_q)
        IDLE:    if (run_i) state_d = SHIFT;
        SHIFT:   if (phase_q && col_last) state_d = LATCH;
        LATCH:   state_d = DISPLAY;
        DISPLAY: if (disp_cnt_q == '0) state_d = NEXT;
        NEXT:    state_d = run_i ? SHIFT : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Counter and pin next values.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    plane_d      = plane_q;
    phase_d      = phase_q;
    disp_cnt_d   = disp_cnt_q;
    hub_clk_d    = hub_clk_q;
    hub_lat_d    = hub_lat_q;
    hub_oe_n_d   = hub_oe_n_q;
    hub_addr_d   = hub_addr_q;
    frame_done_d = 1'b0;
    if (tick_i) begin
      case (state_q)
        IDLE: begin
          if (run_i) begin
            col_d   = '0;
            phase_d = 1'b0;
          end
        end
        SHIFT: begin
          if (!phase_q) begin
            hub_clk_d = 1'b1;
            phase_d   = 1'b1;
          end else begin
            hub_clk_d = 1'b0;
            phase_d   = 1'b0;
            if (!col_last) begin
              col_d = col_q + COL_BITS'(1);
            end else begin
              // OE is still high here, so the address may move safely.
              hub_lat_d  = 1'b1;
              hub_addr_d = row_q;
            end
          end
        end
        LATCH: begin
          hub_lat_d  = 1'b0;
          hub_oe_n_d = 1'b0;
          disp_cnt_d = disp_load;
        end
        DISPLAY: begin
          if (disp_cnt_q == '0) hub_oe_n_d = 1'b1;
          else                  disp_cnt_d = disp_cnt_q - DISP_BITS'(1);
        end
        NEXT: begin
          if (!plane_last) begin
            plane_d = plane_q + PLANE_BITS'(1);
          end else begin
            plane_d = '0;
            row_d   = row_q + ADDR_BITS'(1);
            if (row_last) frame_done_d = 1'b1;
          end
          if (run_i) begin
            col_d   = '0;
            phase_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_d = (state_d != IDLE);

  assign rd_col_o     = col_q;
  assign rd_row_o     = row_q;
  assign rd_plane_o   = plane_q;
  assign hub_clk_o    = hub_clk_q;
  assign hub_lat_o    = hub_lat_q;
  assign hub_oe_n_o   = hub_oe_n_q;
  assign hub_addr_o   = hub_addr_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl with a small panel configuration:
// COLS=4, ADDR_BITS=1, PLANES=2, BASE_TICKS=2. Expected pin timing per
// row-plane, counted in ticks from the edge that enters SHIFT (o=0):
//   hub_clk high at o=1,3,5,7 (columns 0..3), hub_lat high at o=8,
//   hub_oe_n low for o=9..8+D with D=2<<plane, NEXT at o=9+D,
//   so a row-plane lasts 10+D ticks (12 and 14); a frame is 52 ticks.
module tb_hub75_scan_ctrl;

  localparam int COLS       = 4;
  localparam int COL_BITS   = 2;
  localparam int ADDR_BITS  = 1;
  localparam int PLANES     = 2;
  localparam int PLANE_BITS = 1;
  localparam int BASE_TICKS = 2;
  localparam int DISP_BITS  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic tick;
  logic run;
  always #5 clk = ~clk;

  logic [COL_BITS-1:0]   rd_col;
  logic [ADDR_BITS-1:0]  rd_row;
  logic [PLANE_BITS-1:0] rd_plane;
  logic                  hub_clk, hub_lat, hub_oe_n;
  logic [ADDR_BITS-1:0]  hub_addr;
  logic                  busy, frame_done;
  logic [2:0]            state;

  hub75_scan_ctrl #(
    .COLS(COLS), .COL_BITS(COL_BITS), .ADDR_BITS(ADDR_BITS),
    .PLANES(PLANES), .PLANE_BITS(PLANE_BITS),
    .BASE_TICKS(BASE_TICKS), .DISP_BITS(DISP_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_i(tick), .run_i(run),
    .rd_col_o(rd_col), .rd_row_o(rd_row), .rd_plane_o(rd_plane),
    .hub_clk_o(hub_clk), .hub_lat_o(hub_lat), .hub_oe_n_o(hub_oe_n),
    .hub_addr_o(hub_addr), .busy_o(busy), .frame_done_o(frame_done),
    .state_o(state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reset-state pins, sampled while rst_n=0 or right after it.
  task automatic chk_reset_pins(input string tag);
    chk({tag, "_oe_n"}, 8'(hub_oe_n), 8'd1);
    chk({tag, "_clk"},  8'(hub_clk),  8'd0);
    chk({tag, "_lat"},  8'(hub_lat),  8'd0);
    chk({tag, "_addr"}, 8'(hub_addr), 8'd0);
    chk({tag, "_busy"}, 8'(busy),     8'd0);
    chk({tag, "_fd"},   8'(frame_done), 8'd0);
  endtask

  // One row-plane. Each tick is followed by div-1 idle cycles, during which
  // every output must hold. run is dropped before tick o==drop_at.
  task automatic run_seg(input int row, input int plane, input bit fd,
                         input int div, input int drop_at);
    int d;
    int len;
    logic e_clk, e_lat, e_oe_n, e_fd;
    d   = BASE_TICKS << plane;
    len = 10 + d;
    for (int o = 0; o < len; o++) begin
      if (o == drop_at) run = 1'b0;
      for (int h = 0; h < div; h++) begin
        tick = (h == 0);
        @(negedge clk);
        e_clk  = (o >= 1) && (o <= 7) && (o % 2 == 1);
        e_lat  = (o == 8);
        e_oe_n = !((o >= 9) && (o <= 8 + d));
        e_fd   = fd && (o == 0) && (h == 0);
        chk("hub_clk",    8'(hub_clk),    8'(e_clk));
        chk("hub_lat",    8'(hub_lat),    8'(e_lat));
        chk("hub_oe_n",   8'(hub_oe_n),   8'(e_oe_n));
        chk("frame_done", 8'(frame_done), 8'(e_fd));
        chk("busy",       8'(busy),       8'd1);
        chk("rd_row",     8'(rd_row),     8'(row));
        chk("rd_plane",   8'(rd_plane),   8'(plane));
        if (o <= 7) chk("rd_col", 8'(rd_col), 8'(o / 2));
        if (e_lat)  chk("hub_addr", 8'(hub_addr), 8'(row));
      end
    end
    tick = 1'b0;
  endtask

  // ---------------- pin invariants ----------------
  logic                 prev_oe_n = 1'b1;
  logic [ADDR_BITS-1:0] prev_addr = '0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert ((hub_lat & ~hub_oe_n) === 1'b0) else begin
        errors++;
        $error("FAIL lat_with_oe observed=%0b expected=0", hub_lat & ~hub_oe_n);
      end
      if (!hub_oe_n && !prev_oe_n) begin
        checks++;
        assert (hub_addr === prev_addr) else begin
          errors++;
          $error("FAIL addr_during_oe observed=%0h expected=%0h", hub_addr, prev_addr);
        end
      end
    end
    prev_oe_n = hub_oe_n;
    prev_addr = hub_addr;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int budget;
    rst_n = 1'b0;
    tick  = 1'b0;
    run   = 1'b1;

    // Reset held with tick toggling and run high: nothing may move.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tick = ~tick;
      chk_reset_pins("reset_hold");
    end
    @(negedge clk);
    run   = 1'b0;
    tick  = 1'b0;
    rst_n = 1'b1;

    // Idle ticks with run=0 keep the block idle.
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      @(negedge clk);
      chk_reset_pins("idle_norun");
    end

    // Full frame plus one row-plane at one tick per cycle.
    run = 1'b1;
    run_seg(0, 0, 1'b0, 1, -1);
    run_seg(0, 1, 1'b0, 1, -1);
    run_seg(1, 0, 1'b0, 1, -1);
    run_seg(1, 1, 1'b0, 1, -1);
    run_seg(0, 0, 1'b1, 1, -1);

    // Tick every third cycle: every width triples, outputs hold between ticks.
    run_seg(0, 1, 1'b0, 3, -1);
    run_seg(1, 0, 1'b0, 3, -1);
    run_seg(1, 1, 1'b0, 3, -1);
    run_seg(0, 0, 1'b1, 3, -1);

    // Drop run mid-shift of row0/plane1: the row-plane still completes.
    run_seg(0, 1, 1'b0, 1, 3);
    tick = 1'b1;
    @(negedge clk);
    chk("stop_busy",  8'(busy),     8'd0);
    chk("stop_state", 8'(state),    8'd0);
    chk("stop_oe_n",  8'(hub_oe_n), 8'd1);
    chk("stop_row",   8'(rd_row),   8'd1);
    chk("stop_plane", 8'(rd_plane), 8'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stay_idle", 8'(busy), 8'd0);
    end

    // Re-raise run: resumes at row1 / plane0.
    run = 1'b1;
    run_seg(1, 0, 1'b0, 1, -1);

    // Run into DISPLAY, then reset asynchronously between clock edges.
    budget = 0;
    tick = 1'b1;
    while (hub_oe_n !== 1'b0 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    chk("reach_display", 8'(hub_oe_n), 8'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_pins("async_reset");
    @(negedge clk);
    chk_reset_pins("async_hold");
    tick = 1'b0;
    run  = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
Scan/refresh sequencer for a HUB75 LED matrix panel. It advances only on single-cycle `tick` enables from the upstream clock prescaler.
- Walks columns, bit-planes and row addresses of the framebuffer.
- Generates the panel shift clock, latch, output-enable and row address.
- Implements binary-coded modulation: plane p is displayed for BASE_TICKS·2^p ticks.
- Sits between the prescaler, the framebuffer read port and the panel pins.

Parameters:
COLS, 64, columns shifted per row; must be ≥2.
COL_BITS, 6, width of column index; must hold COLS-1.
ADDR_BITS, 4, panel row-address width; scan rows = 2^ADDR_BITS.
PLANES, 4, bit-planes per colour; must be ≥1.
PLANE_BITS, 2, width of plane index; must hold PLANES-1.
BASE_TICKS, 1, OE-low ticks for plane 0; must be ≥1.
DISP_BITS, 8, display counter width; must hold BASE_TICKS·2^(PLANES-1)-1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle enable from prescaler; all sequencing advances only on clk edges with tick=1
run  in  1  1 = keep scanning; sampled on tick in IDLE and NEXT
rd_col  out  COL_BITS  framebuffer column being shifted
rd_row  out  ADDR_BITS  framebuffer row being shifted
rd_plane  out  PLANE_BITS  bit-plane being shifted
hub_clk  out  1  panel shift clock
hub_lat  out  1  panel latch
hub_oe_n  out  1  panel output enable, active low
hub_addr  out  ADDR_BITS  panel row address
busy  out  1  state ≠ IDLE
frame_done  out  1  one-clk pulse at the end of each full frame

Behaviour:
- Registered outputs throughout; no combinational path from inputs to outputs.
- Async reset (rst_n=0):
  - state=IDLE, col=0, row=0, plane=0, phase=0, disp_cnt=0.
  - hub_clk=0, hub_lat=0, hub_oe_n=1, hub_addr=0, frame_done=0, busy=0.
  - Reset mid-sequence blanks the panel immediately (OE_n=1).
- tick=0: state, counters and pins hold. frame_done is forced to 0 on every clk it is not being pulsed.
- IDLE, on tick: if run=1, go to SHIFT with col=0, phase=0; else stay in IDLE.
- SHIFT: each column takes 2 ticks.
  - phase0 tick: hub_clk←1, phase←1.
  - phase1 tick: hub_clk←0, phase←0.
    - If col<COLS-1: col←col+1.
    - If col=COLS-1: state←LATCH, hub_lat←1, hub_addr←rd_row.
  - rd_col is stable across both ticks of its column. Framebuffer data therefore has ≥1 tick before the hub_clk rise.
- LATCH, on tick: hub_lat←0, hub_oe_n←0, disp_cnt←(BASE_TICKS<<plane)-1, state←DISPLAY.
  - hub_lat is high for exactly 1 tick.
  - hub_addr changes only while hub_oe_n=1.
- DISPLAY, on tick:
  - If disp_cnt=0: hub_oe_n←1, state←NEXT.
  - Else disp_cnt←disp_cnt-1.
  - hub_oe_n is low for exactly BASE_TICKS·2^plane ticks.
- NEXT, on tick, advance counters:
  - If plane<PLANES-1: plane+1.
  - Else plane←0 and row←row+1, wrapping at 2^ADDR_BITS.
  - If both plane and row wrap: frame_done←1 for this one clk.
  - Then if run=1: state←SHIFT, col=0; else state←IDLE.
- run deasserted mid-sequence: the current row-plane completes through NEXT, then the block idles. Counters are retained, so scanning resumes at the next row/plane.
- Ticks per row-plane = 2·COLS + 2 + BASE_TICKS·2^plane.
- hub_clk=1 only in SHIFT. hub_lat=1 only in LATCH. hub_oe_n=0 only in DISPLAY.

Test Plan:
1. Reset: hold rst_n=0 with tick toggling → hub_oe_n=1, hub_clk=0, hub_lat=0, hub_addr=0, busy=0, frame_done=0. Assert rst_n=0 asynchronously mid-DISPLAY → hub_oe_n=1 before the next clk edge.
2. COLS=4, ADDR_BITS=1, PLANES=2, BASE_TICKS=2, tick=1 every cycle, run=1:
   - 4 hub_clk pulses with rd_col 0,1,2,3, then hub_lat high 1 cycle, hub_addr=0.
   - hub_oe_n low 2 cycles (plane0), then low 4 cycles (plane1).
   - Row-plane lengths are 12 and 14 ticks.
3. Same config as scenario 2: frame_done pulses exactly once per 52 ticks, on the NEXT of row=1/plane=1. rd_row and rd_plane return to 0 afterwards.
4. tick asserted every 3rd cycle → all pin widths are exactly 3× the scenario 2 values. No state change occurs on tick=0 cycles.
5. Drop run mid-SHIFT of row0/plane1 → sequence completes through DISPLAY (OE low 4 ticks), then IDLE with busy=0. Re-raise run → resumes at row1, plane0.
6. Across all scenarios, check that hub_addr never changes while hub_oe_n=0 and that hub_lat never coincides with hub_oe_n=0.
